// File: rtl/scan_pkg.sv
// Shared definitions for the hex token scanner.
//   scan_state_e : scanner FSM state encoding
//   ERR_*        : err_rx result codes
//   CH_*         : control characters the scanner treats specially
package scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAW   = 3'd1,
    ST_SKIP  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } scan_state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_EMPTY    = 2'b01;
  localparam logic [1:0] ERR_INVALID  = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW = 2'b11;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII classifier for the scanner.
//   byte_i    : input character
//   is_hex_o  : '0'-'9', 'A'-'F' or 'a'-'f'
//   nibble_o  : value of the hex digit (don't care when is_hex_o=0)
//   is_space_o, is_cr_o, is_lf_o : 0x20, 0x0D, 0x0A respectively
module hex_ascii_decode
  import scan_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_hex_o,
  output logic [3:0] nibble_o,
  output logic       is_space_o,
  output logic       is_cr_o,
  output logic       is_lf_o
);

  logic is_dec;
  logic is_alpha;

  assign is_dec   = (byte_i >= 8'h30) && (byte_i <= 8'h39);
  // Upper and lower case letters share the low five bits.
  assign is_alpha = ((byte_i >= 8'h41) && (byte_i <= 8'h46)) ||
                    ((byte_i >= 8'h61) && (byte_i <= 8'h66));

  assign is_hex_o = is_dec || is_alpha;
  // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
  assign nibble_o = is_alpha ? (byte_i[3:0] + 4'd9) : byte_i[3:0];

  assign is_space_o = (byte_i == CH_SPACE);
  assign is_cr_o    = (byte_i == CH_CR);
  assign is_lf_o    = (byte_i == CH_LF);

endmodule

// File: rtl/scan_hex.sv
// Scans one raw byte or one whitespace-delimited hex token from a byte
// stream and reports the value with a one-cycle ack strobe.
//   clk, rstn        : clock, synchronous active-low reset
//   d_rx/vld_rx/rdy_rx : byte stream in
//   req_rx/type_rx   : start a scan (type 0 raw byte, 1 hex token)
//   ack_rx           : result strobe, one cycle
//   flag_rx, err_rx  : error indication / code
//   din_rx           : scanned value
//   state_o          : current FSM state, for observation
// Byte handshake: a byte moves on a rising edge where vld_rx && rdy_rx;
// rdy_rx depends only on the FSM state, never on vld_rx.
module scan_hex
  import scan_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MAX_DIGITS = DATA_W / 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        d_rx,
  input  logic              vld_rx,
  output logic              rdy_rx,
  input  logic              req_rx,
  input  logic              type_rx,
  output logic              ack_rx,
  output logic              flag_rx,
  output logic [1:0]        err_rx,
  output logic [DATA_W-1:0] din_rx,
  output scan_state_e       state_o
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lf_pend_q, lf_pend_d;

  logic       is_hex, is_space, is_cr, is_lf;
  logic [3:0] nibble;
  logic       xfer;

  hex_ascii_decode u_dec (
    .byte_i     (d_rx),
    .is_hex_o   (is_hex),
    .nibble_o   (nibble),
    .is_space_o (is_space),
    .is_cr_o    (is_cr),
    .is_lf_o    (is_lf)
  );

  assign rdy_rx = (state_q == ST_RAW)   || (state_q == ST_SKIP) ||
                  (state_q == ST_DIGIT) || (state_q == ST_DRAIN);
  assign xfer   = vld_rx && rdy_rx;

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    lf_pend_d = lf_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (req_rx) begin
          din_d   = '0;
          cnt_d   = '0;
          err_d   = ERR_OK;
          state_d = type_rx ? ST_SKIP : ST_RAW;
        end
      end
      ST_RAW: begin
        if (xfer) begin
          din_d   = DATA_W'(d_rx);
          err_d   = ERR_OK;
          state_d = ST_DONE;
        end
      end
      ST_SKIP: begin
        if (xfer) begin
          // A CR arms the LF swallow; every other byte disarms it (a
          // swallowed LF consumes the pending flag).
          lf_pend_d = is_cr;
          if (is_space || is_cr) begin
            state_d = ST_SKIP;
          end else if (is_lf) begin
            if (!lf_pend_q) begin
              err_d   = ERR_EMPTY;
              state_d = ST_DONE;
            end
          end else if (is_hex) begin
            din_d   = DATA_W'(nibble);
            cnt_d   = CNT_W'(1);
            state_d = ST_DIGIT;
          end else begin
            err_d   = ERR_INVALID;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DIGIT: begin
        if (xfer) begin
          // lf_pend is always clear in this state, so an LF leaves it clear.
          lf_pend_d = is_cr;
          if (is_hex) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              err_d   = ERR_OVERFLOW;
              state_d = ST_DRAIN;
            end else begin
              din_d = {din_q[DATA_W-5:0], nibble};
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_space || is_lf || is_cr) begin
            err_d   = ERR_OK;
            state_d = ST_DONE;
          end else begin
            err_d   = ERR_INVALID;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer) begin
          lf_pend_d = is_cr;
          if (is_lf || is_cr) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      err_q     <= ERR_OK;
      cnt_q     <= '0;
      lf_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      lf_pend_q <= lf_pend_d;
    end
  end

  assign ack_rx  = (state_q == ST_DONE);
  assign flag_rx = (err_q != ERR_OK);
  assign err_rx  = err_q;
  assign din_rx  = din_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_scan_hex.sv
module tb_scan_hex;
  import scan_pkg::*;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rstn;
  logic [7:0]        d_rx;
  logic              vld_rx;
  logic              rdy_rx;
  logic              req_rx;
  logic              type_rx;
  logic              ack_rx;
  logic              flag_rx;
  logic [1:0]        err_rx;
  logic [DATA_W-1:0] din_rx;
  scan_state_e       state_o;

  int n_vec = 0;
  int n_err = 0;

  // Expected results: {err, din}
  logic [DATA_W+1:0] exp_q[$];

  scan_hex #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .req_rx  (req_rx),
    .type_rx (type_rx),
    .ack_rx  (ack_rx),
    .flag_rx (flag_rx),
    .err_rx  (err_rx),
    .din_rx  (din_rx),
    .state_o (state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rstn && ack_rx) begin
      chk("ack_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [DATA_W+1:0] e;
        e = exp_q.pop_front();
        chk("din", 64'(din_rx), 64'(e[DATA_W-1:0]));
        chk("err", 64'(err_rx), 64'(e[DATA_W+1:DATA_W]));
        chk("flag", 64'(flag_rx), 64'(e[DATA_W+1:DATA_W] != 2'b00));
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n;
    d_rx   = b;
    vld_rx = 1'b1;
    n = 0;
    while (!rdy_rx && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_rx) chk("rdy_timeout", 64'(rdy_rx), 64'd1);
    @(negedge clk);
    vld_rx = 1'b0;
  endtask

  task automatic start_req(input logic t);
    @(negedge clk);
    req_rx  = 1'b1;
    type_rx = t;
    @(negedge clk);
    req_rx  = 1'b0;
    type_rx = 1'b0;
  endtask

  task automatic scan(input logic t, input string s, input logic [DATA_W-1:0] ed,
                      input logic [1:0] ee);
    exp_q.push_back({ee, ed});
    start_req(t);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (i < s.len() - 1) chk({"ack_early_", s}, 64'(ack_rx), 64'd0);
      else                 chk({"ack_latency_", s}, 64'(ack_rx), 64'd1);
    end
    @(negedge clk);
    chk("ack_one_cycle", 64'(ack_rx), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; d_rx = 8'h00; vld_rx = 1'b0; req_rx = 1'b0; type_rx = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state_o), 64'(ST_IDLE));
    chk("rst_rdy", 64'(rdy_rx), 64'd0);
    chk("rst_ack", 64'(ack_rx), 64'd0);
    chk("rst_din", 64'(din_rx), 64'd0);
    chk("rst_err", 64'(err_rx), 64'd0);
    rstn = 1'b1;

    // Raw byte
    scan(1'b0, "A", 32'h0000_0041, ERR_OK);
    // Leading spaces, CR terminator; the pending LF opens the next scan
    scan(1'b1, "  1aF3\r", 32'h0000_1AF3, ERR_OK);
    scan(1'b1, "\n7 ", 32'h7, ERR_OK);
    // Empty token
    scan(1'b1, "\n", 32'h0, ERR_EMPTY);
    // Invalid character, then overflow
    scan(1'b1, "12g4\n", 32'h12, ERR_INVALID);
    scan(1'b1, "123456789\n", 32'h1234_5678, ERR_OVERFLOW);
    // Exactly MAX_DIGITS digits is legal
    scan(1'b1, "FFFFFFFF ", 32'hFFFF_FFFF, ERR_OK);
    // CR LF inside SKIP is swallowed without ending the scan
    scan(1'b1, "\r\nC ", 32'hC, ERR_OK);
    // Invalid first char drained by CR; following LF swallowed next time
    scan(1'b1, "z\r", 32'h0, ERR_INVALID);
    scan(1'b1, "\nBEEF\n", 32'hBEEF, ERR_OK);
    // Raw mode passes control characters through
    scan(1'b0, "\n", 32'h0A, ERR_OK);

    // Reset mid-token: no ack, outputs cleared
    start_req(1'b1);
    send_byte("A");
    send_byte("B");
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("midrst_state", 64'(state_o), 64'(ST_IDLE));
    chk("midrst_rdy", 64'(rdy_rx), 64'd0);
    chk("midrst_ack", 64'(ack_rx), 64'd0);
    chk("midrst_flag", 64'(flag_rx), 64'd0);
    chk("midrst_err", 64'(err_rx), 64'd0);
    chk("midrst_din", 64'(din_rx), 64'd0);
    scan(1'b1, "5 ", 32'h5, ERR_OK);

    // req_rx held high during DIGIT has no effect
    exp_q.push_back({ERR_OK, 32'h34});
    start_req(1'b1);
    send_byte("3");
    req_rx  = 1'b1;
    type_rx = 1'b0;
    send_byte("4");
    chk("held_req_state", 64'(state_o), 64'(ST_DIGIT));
    chk("held_req_rdy", 64'(rdy_rx), 64'd1);
    send_byte(" ");
    chk("held_req_ack", 64'(ack_rx), 64'd1);
    req_rx = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("held_req_idle", 64'(state_o), 64'(ST_IDLE));
    // Result holds after the ack
    chk("hold_din", 64'(din_rx), 64'h34);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
